sw_debounce8: RTL and testbench



---
 rtl/sw_pkg.sv | 9 +
 rtl/sw_debounce8_if.sv | 21 ++
 rtl/debounce_bit.sv | 47 ++++
 rtl/sw_debounce8.sv | 58 +++++
 tb/tb_sw_debounce8.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
// Shared switch-vector types and defaults for the switch front end and the priority encoder.
package sw_pkg;

  localparam int unsigned N_SW                = 8;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

  typedef logic [N_SW-1:0] sw_vec_t;

endpackage

// File: rtl/sw_debounce8_if.sv
// Switch-conditioning signal bundle: raw switches in, clean vector and status out.
// Optional rise/fall edge vectors exist only when SW_DEBOUNCE_EDGE_EN is defined.
interface sw_debounce8_if;
  import sw_pkg::*;

  sw_vec_t sw_in;
  sw_vec_t sw_out;
  logic    changed;
  logic    any_on;
`ifdef SW_DEBOUNCE_EDGE_EN
  sw_vec_t rise;
  sw_vec_t fall;

  modport master (output sw_in, input sw_out, changed, any_on, rise, fall);
  modport slave  (input sw_in, output sw_out, changed, any_on, rise, fall);
`else
  modport master (output sw_in, input sw_out, changed, any_on);
  modport slave  (input sw_in, output sw_out, changed, any_on);
`endif

endinterface

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchroniser, qualification counter and debounced level.
// flip is the strobe that is high in the cycle whose closing edge updates db.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic flip
);

  localparam int unsigned       CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Any cycle where s2 agrees with db restarts the window; the counter saturates by flipping.
  always_comb begin
    cnt_nxt = '0;
    flip    = 1'b0;
    if (s2 != db) begin
      if (cnt == CNT_MAX) flip    = 1'b1;
      else                cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      cnt <= cnt_nxt;
      if (flip) db <= s2;
    end
  end

endmodule

// File: rtl/sw_debounce8.sv
// Eight independent switch debouncers with change/any-on status for the 8-to-3 encoder.
// Define SW_DEBOUNCE_EDGE_EN to add registered per-bit rise/fall pulses.
module sw_debounce8
  import sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  sw_debounce8_if.slave  bus
);

  sw_vec_t db;
  sw_vec_t flip;
  logic    changed_q;

  for (genvar i = 0; i < int'(N_SW); i++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.sw_in[i]),
      .db   (db[i]),
      .flip (flip[i])
    );
  end

  // Simultaneous flips on several channels collapse into one pulse.
  always_ff @(posedge clk) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= |flip;
  end

  assign bus.sw_out  = db;
  assign bus.changed = changed_q;
  assign bus.any_on  = |db;

`ifdef SW_DEBOUNCE_EDGE_EN
  sw_vec_t rise_q;
  sw_vec_t fall_q;

  // db still holds the pre-flip level here, so it tells the direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= flip & ~db;
      fall_q <= flip & db;
    end
  end

  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
`endif

endmodule

// File: tb/tb_sw_debounce8.sv
// Directed bench for sw_debounce8 (DEBOUNCE_CYCLES = 4) with a windowed reference model.
module tb_sw_debounce8;
  import sw_pkg::*;

  localparam int D    = 4;
  localparam int HMAX = 1024;

  logic clk;
  logic rst;

  sw_debounce8_if bus ();

  sw_debounce8 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a bit flips when the last D synchronised samples, all taken after its last
  // flip or reset, disagree with its current debounced level.
  logic [7:0] hist_in  [0:HMAX-1];
  bit         hist_rst [0:HMAX-1];
  int         k = 0;
  int         last_ev [8];
  logic [7:0] m_db      = '0;
  logic       m_changed = 1'b0;
  logic [7:0] m_rise    = '0;
  logic [7:0] m_fall    = '0;
  bit         started   = 1'b0;

  function automatic logic [7:0] s2_seen(input int j);
    if (j < 2) return 8'h00;
    if (hist_rst[j-1] || hist_rst[j-2]) return 8'h00;
    return hist_in[j-2];
  endfunction

  always @(posedge clk) begin
    logic [7:0] fl;
    logic [7:0] s;
    bit         ok;
    if (k >= HMAX) begin
      $display("FAIL model_history: got %0d expected below %0d", k, HMAX);
      $fatal(1);
    end
    hist_in[k]  = bus.sw_in;
    hist_rst[k] = rst;
    fl = '0;
    if (rst) begin
      m_db = '0;
      for (int i = 0; i < 8; i++) last_ev[i] = k;
    end else begin
      for (int i = 0; i < 8; i++) begin
        ok = (k - last_ev[i]) >= D;
        if (ok) begin
          for (int j = k - D + 1; j <= k; j++) begin
            s = s2_seen(j);
            if (s[i] == m_db[i]) ok = 1'b0;
          end
        end
        if (ok) begin
          fl[i]      = 1'b1;
          last_ev[i] = k;
        end
      end
    end
    m_rise    = fl & ~m_db;
    m_fall    = fl & m_db;
    m_db      = m_db ^ fl;
    m_changed = |fl;
    started   = 1'b1;
    k++;
  end

  always @(negedge clk) begin
    if (started) begin
      check("sw_out",  bus.sw_out,             m_db);
      check("changed", {7'b0, bus.changed},    {7'b0, m_changed});
      check("any_on",  {7'b0, bus.any_on},     {7'b0, |m_db});
`ifdef SW_DEBOUNCE_EDGE_EN
      check("rise",    bus.rise,               m_rise);
      check("fall",    bus.fall,               m_fall);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    bus.sw_in  = 8'hFF;

    // Reset held with switches high, then re-qualification after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_sw_out",  bus.sw_out, 8'h00);
    check("rst_changed", {7'b0, bus.changed}, 8'h00);
    rst = 1'b0;
    step(5);
    check("rel_pre_sw_out", bus.sw_out, 8'h00);
    step(1);
    check("rel_sw_out",  bus.sw_out, 8'hFF);
    check("rel_changed", {7'b0, bus.changed}, 8'h01);
    step(1);
    check("rel_changed_drop", {7'b0, bus.changed}, 8'h00);
    bus.sw_in = 8'h00;
    step(8);
    check("clr_sw_out", bus.sw_out, 8'h00);
    check("clr_any_on", {7'b0, bus.any_on}, 8'h00);

    // Clean single-bit change.
    bus.sw_in = 8'h10;
    step(5);
    check("clean_pre", bus.sw_out, 8'h00);
    step(1);
    check("clean_sw_out",  bus.sw_out, 8'h10);
    check("clean_changed", {7'b0, bus.changed}, 8'h01);
    check("clean_any_on",  {7'b0, bus.any_on}, 8'h01);
    step(1);
    check("clean_changed_drop", {7'b0, bus.changed}, 8'h00);
    bus.sw_in = 8'h00;
    step(8);

    // Bounce on bit 3, then hold.
    for (int t = 0; t < 4; t++) begin
      bus.sw_in = (t % 2 == 0) ? 8'h08 : 8'h00;
      step(1);
      check("bounce_hold", bus.sw_out, 8'h00);
    end
    bus.sw_in = 8'h08;
    step(5);
    check("bounce_pre", bus.sw_out, 8'h00);
    step(1);
    check("bounce_sw_out", bus.sw_out, 8'h08);

    // Glitch on bit 7 shorter than the window.
    step(2);
    bus.sw_in = 8'h88;
    step(3);
    bus.sw_in = 8'h08;
    step(8);
    check("glitch_sw_out", bus.sw_out, 8'h08);

    // Bits 0 and 5 together.
    bus.sw_in = 8'h29;
    step(5);
    check("simul_pre", bus.sw_out, 8'h08);
    step(1);
    check("simul_sw_out",  bus.sw_out, 8'h29);
    check("simul_changed", {7'b0, bus.changed}, 8'h01);
    step(1);
    check("simul_changed_drop", {7'b0, bus.changed}, 8'h00);

    // Bit 2 one cycle after bit 1.
    bus.sw_in = 8'h2B;
    step(1);
    bus.sw_in = 8'h2F;
    step(5);
    check("ovl_first",    bus.sw_out, 8'h2B);
    check("ovl_changed1", {7'b0, bus.changed}, 8'h01);
    step(1);
    check("ovl_second",   bus.sw_out, 8'h2F);
    check("ovl_changed2", {7'b0, bus.changed}, 8'h01);
    step(1);
    check("ovl_changed_drop", {7'b0, bus.changed}, 8'h00);

    // Fall of a single bit: 01 -> 00.
    bus.sw_in = 8'h01;
    step(8);
    check("fall_setup", bus.sw_out, 8'h01);
    bus.sw_in = 8'h00;
    step(6);
    check("fall_sw_out", bus.sw_out, 8'h00);
`ifdef SW_DEBOUNCE_EDGE_EN
    check("fall_fall", bus.fall, 8'h01);
    check("fall_rise", bus.rise, 8'h00);
    step(1);
    check("fall_fall_drop", bus.fall, 8'h00);
`endif

    // Reset in the middle of a qualification window.
    bus.sw_in = 8'hFF;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.sw_in = 8'h00;
    step(8);
    check("midrst_sw_out",  bus.sw_out, 8'h00);
    check("midrst_changed", {7'b0, bus.changed}, 8'h00);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
